// File: rtl/axi_wr_dev_router.sv
// Routes AXI write-slave bursts to one of four address-decoded devices, arbitrating
// device 0 against a local sequencer and aborting bursts that stall too long.
module axi_wr_dev_router #(
    parameter int                      ADDRESS_BITS = 10,
    parameter logic [ADDRESS_BITS-1:0] DEV0_BASE    = ADDRESS_BITS'(0) << (ADDRESS_BITS-2),
    parameter logic [ADDRESS_BITS-1:0] DEV1_BASE    = ADDRESS_BITS'(1) << (ADDRESS_BITS-2),
    parameter logic [ADDRESS_BITS-1:0] DEV2_BASE    = ADDRESS_BITS'(2) << (ADDRESS_BITS-2),
    parameter logic [ADDRESS_BITS-1:0] DEV3_BASE    = ADDRESS_BITS'(3) << (ADDRESS_BITS-2),
    parameter logic [ADDRESS_BITS-1:0] DEV0_MASK    = {2'b11, {(ADDRESS_BITS-2){1'b0}}},
    parameter logic [ADDRESS_BITS-1:0] DEV1_MASK    = {2'b11, {(ADDRESS_BITS-2){1'b0}}},
    parameter logic [ADDRESS_BITS-1:0] DEV2_MASK    = {2'b11, {(ADDRESS_BITS-2){1'b0}}},
    parameter logic [ADDRESS_BITS-1:0] DEV3_MASK    = {2'b11, {(ADDRESS_BITS-2){1'b0}}},
    parameter int                      TIMEOUT      = 256
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [ADDRESS_BITS-1:0] pre_awaddr,
    input  logic [3:0]              pre_awlen,
    input  logic                    start_burst,
    input  logic                    bram_wen,
    output logic                    dev_ready,
    input  logic [3:0]              dev_rdy_in,
    output logic [3:0]              dev_wen,
    output logic [1:0]              sel,
    output logic                    busy,
    input  logic                    loc_req,
    output logic                    loc_gnt,
    output logic                    err_unmapped,
    output logic                    err_timeout,
    input  logic                    err_clr
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          r_state;
    logic [1:0]      r_sel;
    logic            r_unmapped;
    logic [3:0]      r_remaining;
    logic            r_abort;
    logic [TW-1:0]   r_tcnt;
    logic            r_loc_gnt;
    logic            r_err_unmapped;
    logic            r_err_timeout;

    logic [3:0]      w_hit;
    logic [1:0]      w_dec_sel;
    logic            w_dec_unmapped;
    logic            w_burst_live;
    logic            w_dev0_claim;
    logic            w_tmo_hit;

    // Unmapped/aborted targets report ready so the write slave drains the burst.
    function automatic logic rdy_of(input logic [1:0] idx, input logic force_rdy,
                                    input logic [3:0] rdy, input logic gnt);
        if (force_rdy)
            return 1'b1;
        if (idx == 2'd0 && gnt)
            return 1'b0;
        return rdy[idx];
    endfunction

    assign w_hit[0] = (pre_awaddr & DEV0_MASK) == DEV0_BASE;
    assign w_hit[1] = (pre_awaddr & DEV1_MASK) == DEV1_BASE;
    assign w_hit[2] = (pre_awaddr & DEV2_MASK) == DEV2_BASE;
    assign w_hit[3] = (pre_awaddr & DEV3_MASK) == DEV3_BASE;

    always_comb begin
        w_dec_sel      = 2'd0;
        w_dec_unmapped = 1'b0;
        if (w_hit[0])      w_dec_sel = 2'd0;
        else if (w_hit[1]) w_dec_sel = 2'd1;
        else if (w_hit[2]) w_dec_sel = 2'd2;
        else if (w_hit[3]) w_dec_sel = 2'd3;
        else               w_dec_unmapped = 1'b1;
    end

    assign w_burst_live = (r_state == S_BURST) && !r_unmapped && !r_abort;
    // Device 0 is claimed by the AXI side from the start strobe onward.
    assign w_dev0_claim = (w_burst_live && r_sel == 2'd0) ||
                          (start_burst && !w_dec_unmapped && w_dec_sel == 2'd0);
    assign w_tmo_hit    = (r_state == S_BURST) && !start_burst && !bram_wen &&
                          (r_tcnt == TW'(TIMEOUT-1));

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_sel          <= 2'd0;
            r_unmapped     <= 1'b0;
            r_remaining    <= 4'd0;
            r_abort        <= 1'b0;
            r_tcnt         <= '0;
            r_loc_gnt      <= 1'b0;
            r_err_unmapped <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_loc_gnt <= loc_req && (r_loc_gnt || !w_dev0_claim);

            if (start_burst && w_dec_unmapped) r_err_unmapped <= 1'b1;
            else if (err_clr)                  r_err_unmapped <= 1'b0;

            if (w_tmo_hit)    r_err_timeout <= 1'b1;
            else if (err_clr) r_err_timeout <= 1'b0;

            if (start_burst) begin
                r_state     <= S_BURST;
                r_sel       <= w_dec_sel;
                r_unmapped  <= w_dec_unmapped;
                r_remaining <= pre_awlen;
                r_abort     <= 1'b0;
                r_tcnt      <= '0;
            end else if (r_state == S_BURST) begin
                if (bram_wen) begin
                    r_tcnt <= '0;
                    if (r_remaining == 4'd0)
                        r_state <= S_IDLE;
                    else
                        r_remaining <= r_remaining - 4'd1;
                end else if (w_tmo_hit) begin
                    r_abort <= 1'b1;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
        end
    end

    always_comb begin
        dev_ready = 1'b0;
        if (!rst) begin
            if (start_burst)
                dev_ready = rdy_of(w_dec_sel, w_dec_unmapped, dev_rdy_in, r_loc_gnt);
            else if (r_state == S_BURST)
                dev_ready = rdy_of(r_sel, r_unmapped || r_abort, dev_rdy_in, r_loc_gnt);
        end
    end

    always_comb begin
        dev_wen = 4'd0;
        if (!rst && w_burst_live && bram_wen)
            dev_wen[r_sel] = 1'b1;
    end

    assign sel          = r_sel;
    assign busy         = (r_state == S_BURST);
    assign loc_gnt      = r_loc_gnt;
    assign err_unmapped = r_err_unmapped;
    assign err_timeout  = r_err_timeout;

endmodule
